pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage program-counter controller for the 16-bit WISC datapath. Owns the architectural PC register and drives the PC+2 increment path. Each cycle it picks the next PC from sequential increment, control-flow redirect, exception vector or RTI return. It also tracks run/handler/halted state and holds the PC on stalls.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- EXC_VECTOR, 16'h0002, handler entry address loaded on exception

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle (hazard/memory stall)
- redirect  in  1  taken branch/jump resolved this cycle
- redirect_pc  in  16  target for redirect
- except  in  1  exception/SIIC raised this cycle
- exc_ret_pc  in  16  return address captured into EPC on except
- rti  in  1  return-from-interrupt this cycle
- halt  in  1  HALT instruction committed this cycle
- pc  out  16  current fetch PC (registered)
- pc_inc  out  16  pc + 2, combinational, modulo 2^16
- epc  out  16  saved exception return address (registered)
- fetch_valid  out  1  fetch at pc is live this cycle
- in_handler  out  1  state == HANDLER
- halted  out  1  state == HALTED
- fetch_count  out  16  number of cycles PC advanced, wrapping

## Operation
- States: RUN, HANDLER, HALTED. Encoding is free.
- Next-PC priority, evaluated each edge, highest first:
  1. rst: pc=RESET_PC, epc=0, state=RUN, fetch_count=0.
  2. state HALTED: all registers hold; every input is ignored.
  3. halt: state=HALTED, pc holds.
  4. except in RUN: epc=exc_ret_pc, pc=EXC_VECTOR, state=HANDLER.
  5. except in HANDLER (double fault): state=HALTED, pc and epc hold.
  6. rti: pc=epc, state=RUN. Legal in RUN too, where it acts as a redirect to epc with state unchanged.
  7. redirect: pc=redirect_pc. Overrides stall.
  8. stall: pc holds.
  9. otherwise: pc=pc_inc.
- Only the highest-priority event acts. A lower-priority event in the same cycle is dropped, not queued.
- fetch_count increments by 1, wrapping at 16'hFFFF→0, on every edge where pc takes a new value by rules 4, 6, 7 or 9. It does not increment on hold, halt, double fault or reset.
- pc_inc wraps: pc=16'hFFFE gives pc_inc=16'h0000. Carry out is discarded.
- fetch_valid = (state != HALTED) & ~stall, combinational.
- redirect_pc and EXC_VECTOR are used as given. Odd addresses are not checked.

## Timing
- All registered outputs change only on the rising clk edge. Inputs are sampled on that same edge.
- Latency: an event sampled at edge N is visible on pc/epc/state outputs after edge N, i.e. in cycle N+1.
- pc_inc and fetch_valid track pc/state/stall combinationally within the cycle.
- Reset values: pc=RESET_PC, pc_inc=RESET_PC+2, epc=0, in_handler=0, halted=0, fetch_count=0. fetch_valid=~stall.
- rst asserted mid-handler or while HALTED overrides all other inputs and restores the reset values at the next edge.
- No handshakes. Every input is a single-cycle level qualified by the edge at which it is high. A level held for k cycles acts k times.

## Test plan
- Reset then 4 free-running cycles: pc = 0000, 0002, 0004, 0006, 0008; fetch_count=4; fetch_valid=1 throughout.
- pc=0004 with stall high for 2 cycles, then redirect with redirect_pc=0100 while stall is still high: pc holds 0004 for 2 cycles, then becomes 0100. fetch_count increments only on the redirect.
- At pc=0010, except with exc_ret_pc=0012: next pc=0002, epc=0012, in_handler=1. Then rti: pc=0012, in_handler=0. A second except while in HANDLER: halted=1 and pc frozen.
- Same cycle: halt+except+redirect → HALTED, pc unchanged. Then 5 cycles of random inputs: all outputs stable, fetch_valid=0. Then rst → pc=RESET_PC, halted=0.
- Wrap: force pc to FFFE via redirect, then 1 free cycle: pc=0000 and pc_inc=0002. Separately, preset fetch_count=FFFF (≥65535 advancing cycles), then 1 more advance: fetch_count=0000.
- rst asserted in HANDLER with except also high: after the edge pc=RESET_PC, epc=0, in_handler=0, halted=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns the architectural PC and EPC, chooses the next
// fetch address by fixed priority, and tracks RUN / HANDLER / HALTED state.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        except,
    input  logic [15:0] exc_ret_pc,
    input  logic        rti,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic [15:0] epc,
    output logic        fetch_valid,
    output logic        in_handler,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   epc_q, epc_d;
    logic [W-1:0]   fetch_count_q, fetch_count_d;
    logic           advance;

    // PC+2 increment path; carry out is dropped so FFFE wraps to 0000.
    assign pc_inc = pc_q + W'(2);

    // Next-state selection; only the highest-priority event acts.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        advance = 1'b0;

        if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
        end else if (halt) begin
            state_d = ST_HALTED;
        end else if (except) begin
            if (state_q == ST_RUN) begin
                epc_d   = exc_ret_pc;
                pc_d    = EXC_VECTOR;
                state_d = ST_HANDLER;
                advance = 1'b1;
            end else begin
                // Fault while already in the handler is unrecoverable.
                state_d = ST_HALTED;
            end
        end else if (rti) begin
            pc_d    = epc_q;
            state_d = ST_RUN;
            advance = 1'b1;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            advance = 1'b1;
        end else if (!stall) begin
            pc_d    = pc_inc;
            advance = 1'b1;
        end

        fetch_count_d = advance ? (fetch_count_q + W'(1)) : fetch_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            epc_q         <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign fetch_count = fetch_count_q;
    assign in_handler  = (state_q == ST_HANDLER);
    assign halted      = (state_q == ST_HALTED);
    assign fetch_valid = (state_q != ST_HALTED) & ~stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] EXC_PC = 16'h0002;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, except, rti, halt;
    logic [15:0] redirect_pc, exc_ret_pc;
    logic [15:0] pc, pc_inc, epc, fetch_count;
    logic        fetch_valid, in_handler, halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .except(except), .exc_ret_pc(exc_ret_pc),
        .rti(rti), .halt(halt), .pc(pc), .pc_inc(pc_inc), .epc(epc),
        .fetch_valid(fetch_valid), .in_handler(in_handler), .halted(halted),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic        stall, redirect;
        logic [15:0] rpc;
        logic        exc;
        logic [15:0] eret;
        logic        rti, halt;
        logic [15:0] e_pc, e_epc;
        logic        e_hnd, e_hlt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic rd, logic [15:0] rp, logic ex, logic [15:0] er,
                                logic rt, logic h, logic [15:0] ep, logic [15:0] ee,
                                logic eh, logic el, logic [15:0] ec);
        vec_t v;
        v.stall = s; v.redirect = rd; v.rpc = rp; v.exc = ex; v.eret = er;
        v.rti = rt; v.halt = h; v.e_pc = ep; v.e_epc = ee; v.e_hnd = eh;
        v.e_hlt = el; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                         input logic ex, input logic [15:0] er, input logic rt, input logic h);
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        except = ex; exc_ret_pc = er; rti = rt; halt = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural state plus a mode index (0 run, 1 handler, 2 halted).
    logic [15:0] m_pc, m_epc, m_cnt;
    int          m_mode;

    task automatic model_reset();
        m_pc = RST_PC; m_epc = 16'h0000; m_cnt = 16'h0000; m_mode = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_mode == 2) return;
        if (halt) begin
            m_mode = 2;
            return;
        end
        if (except) begin
            if (m_mode == 1) begin
                m_mode = 2;
                return;
            end
            m_epc = exc_ret_pc; m_pc = EXC_PC; m_mode = 1; m_cnt = m_cnt + 16'd1;
            return;
        end
        if (rti) begin
            m_pc = m_epc; m_mode = 0; m_cnt = m_cnt + 16'd1;
            return;
        end
        if (redirect) begin
            m_pc = redirect_pc; m_cnt = m_cnt + 16'd1;
            return;
        end
        if (stall) return;
        m_pc = 16'((32'(m_pc) + 32'd2) % 32'h10000);
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_check(input int cyc);
        logic [15:0] exp_inc;
        exp_inc = 16'((32'(m_pc) + 32'd2) % 32'h10000);
        chk($sformatf("rnd%0d_pc", cyc), pc, m_pc);
        chk($sformatf("rnd%0d_pc_inc", cyc), pc_inc, exp_inc);
        chk($sformatf("rnd%0d_epc", cyc), epc, m_epc);
        chk($sformatf("rnd%0d_cnt", cyc), fetch_count, m_cnt);
        chk($sformatf("rnd%0d_hnd", cyc), 16'(in_handler), 16'(m_mode == 1));
        chk($sformatf("rnd%0d_hlt", cyc), 16'(halted), 16'(m_mode == 2));
        chk($sformatf("rnd%0d_fv", cyc), 16'(fetch_valid), 16'((m_mode != 2) && !stall));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed table: inputs applied for one edge, expected state after that edge.
        vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0002,16'h0000,0,0,16'd1));
        vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0004,16'h0000,0,0,16'd2));
        vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0006,16'h0000,0,0,16'd3));
        vecs.push_back(mk(0,0,16'h0000,0,16'h0000,0,0, 16'h0008,16'h0000,0,0,16'd4));
        vecs.push_back(mk(0,1,16'h0004,0,16'h0000,0,0, 16'h0004,16'h0000,0,0,16'd5));
        vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0,0, 16'h0004,16'h0000,0,0,16'd5));
        vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0,0, 16'h0004,16'h0000,0,0,16'd5));
        vecs.push_back(mk(1,1,16'h0100,0,16'h0000,0,0, 16'h0100,16'h0000,0,0,16'd6));
        vecs.push_back(mk(0,1,16'h0010,0,16'h0000,0,0, 16'h0010,16'h0000,0,0,16'd7));
        vecs.push_back(mk(0,0,16'h0000,1,16'h0012,0,0, 16'h0002,16'h0012,1,0,16'd8));
        vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1,0, 16'h0012,16'h0012,0,0,16'd9));
        vecs.push_back(mk(0,1,16'h0200,0,16'h0000,1,0, 16'h0012,16'h0012,0,0,16'd10));
        vecs.push_back(mk(0,1,16'h0200,1,16'h0020,1,0, 16'h0002,16'h0020,1,0,16'd11));
        vecs.push_back(mk(0,1,16'h0300,0,16'h0000,1,0, 16'h0020,16'h0020,0,0,16'd12));
        vecs.push_back(mk(0,0,16'h0000,1,16'h0040,0,0, 16'h0002,16'h0040,1,0,16'd13));
        vecs.push_back(mk(1,1,16'h0500,0,16'h0000,0,0, 16'h0500,16'h0040,1,0,16'd14));
        vecs.push_back(mk(0,0,16'h0000,1,16'h0060,0,0, 16'h0500,16'h0040,0,1,16'd14));
        vecs.push_back(mk(0,1,16'h0700,0,16'h0000,1,0, 16'h0500,16'h0040,0,1,16'd14));
        vecs.push_back(mk(1,0,16'h0000,1,16'h0070,0,0, 16'h0500,16'h0040,0,1,16'd14));

        // Reset state.
        drive(1,0,0,16'h0,0,16'h0,0,0);
        tick(); tick();
        drive(0,0,0,16'h0,0,16'h0,0,0);
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_inc", pc_inc, RST_PC + 16'd2);
        chk("rst_epc", epc, 16'h0000);
        chk("rst_cnt", fetch_count, 16'h0000);
        chk("rst_hnd", 16'(in_handler), 16'd0);
        chk("rst_hlt", 16'(halted), 16'd0);
        chk("rst_fv", 16'(fetch_valid), 16'd1);
        stall = 1'b1;
        #1;
        chk("rst_fv_stall", 16'(fetch_valid), 16'd0);

        foreach (vecs[i]) begin
            drive(0, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].exc,
                  vecs[i].eret, vecs[i].rti, vecs[i].halt);
            tick();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_epc", i), epc, vecs[i].e_epc);
            chk($sformatf("vec%0d_cnt", i), fetch_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_hnd", i), 16'(in_handler), 16'(vecs[i].e_hnd));
            chk($sformatf("vec%0d_hlt", i), 16'(halted), 16'(vecs[i].e_hlt));
            chk($sformatf("vec%0d_fv", i), 16'(fetch_valid),
                16'(!vecs[i].e_hlt && !vecs[i].stall));
        end

        // halt + except + redirect together, then random inputs while halted, then reset.
        drive(1,0,0,16'h0,0,16'h0,0,0); tick();
        drive(0,0,1,16'h0400,1,16'h0044,0,1); tick();
        chk("hsim_hlt", 16'(halted), 16'd1);
        chk("hsim_pc", pc, RST_PC);
        chk("hsim_cnt", fetch_count, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
                  16'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk($sformatf("hold%0d_pc", k), pc, RST_PC);
            chk($sformatf("hold%0d_epc", k), epc, 16'h0000);
            chk($sformatf("hold%0d_cnt", k), fetch_count, 16'h0000);
            chk($sformatf("hold%0d_hlt", k), 16'(halted), 16'd1);
            chk($sformatf("hold%0d_fv", k), 16'(fetch_valid), 16'd0);
        end
        drive(1,0,0,16'h0,0,16'h0,0,0); tick();
        chk("unhalt_pc", pc, RST_PC);
        chk("unhalt_hlt", 16'(halted), 16'd0);

        // Reset in HANDLER with except also high.
        drive(0,0,0,16'h0,1,16'h1234,0,0); tick();
        chk("hnd_enter", 16'(in_handler), 16'd1);
        chk("hnd_epc", epc, 16'h1234);
        drive(1,0,0,16'h0,1,16'h5678,0,0); tick();
        chk("hrst_pc", pc, RST_PC);
        chk("hrst_epc", epc, 16'h0000);
        chk("hrst_hnd", 16'(in_handler), 16'd0);
        chk("hrst_hlt", 16'(halted), 16'd0);
        chk("hrst_cnt", fetch_count, 16'h0000);

        // Wrap via redirect to FFFE.
        drive(0,0,1,16'hFFFE,0,16'h0,0,0); tick();
        chk("wrapr_pc", pc, 16'hFFFE);
        chk("wrapr_inc", pc_inc, 16'h0000);
        drive(0,0,0,16'h0,0,16'h0,0,0); tick();
        chk("wrapf_pc", pc, 16'h0000);
        chk("wrapf_inc", pc_inc, 16'h0002);

        // Counter wrap: 65535 advances from reset, then one more.
        drive(1,0,0,16'h0,0,16'h0,0,0); tick();
        drive(0,0,0,16'h0,0,16'h0,0,0);
        repeat (65535) @(posedge clk);
        #1;
        chk("cntw_cnt", fetch_count, 16'hFFFF);
        chk("cntw_pc", pc, 16'hFFFE);
        chk("cntw_inc", pc_inc, 16'h0000);
        tick();
        chk("cntw2_cnt", fetch_count, 16'h0000);
        chk("cntw2_pc", pc, 16'h0000);

        // Randomized traffic against the reference model.
        drive(1,0,0,16'h0,0,16'h0,0,0); tick();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) == 0),
                  16'($urandom),
                  1'($urandom_range(0, 9) == 0),
                  16'($urandom),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 79) == 0));
            model_step();
            tick();
            model_check(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
